// File: rtl/flit_requester_if.sv
// Flit requester bus: upstream flit handshake, arbiter req/grant and the
// downstream flit outputs with the preempt / sequence-error pulses.
interface flit_requester_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_flit_id;
  logic [11:0]       in_length;
  logic [DATA_W-1:0] in_data;
  logic              grant;
  logic              req;
  logic              out_valid;
  logic [2:0]        out_flit_id;
  logic [11:0]       out_length;
  logic [DATA_W-1:0] out_data;
  logic              preempt;
  logic              err_seq;

  // The requester itself drives the ready, request and flit outputs.
  modport master (
    input  in_valid, in_flit_id, in_length, in_data, grant,
    output in_ready, req, out_valid, out_flit_id, out_length, out_data,
           preempt, err_seq
  );

  // The environment: upstream flit source, arbiter and downstream sink.
  modport slave (
    output in_valid, in_flit_id, in_length, in_data, grant,
    input  in_ready, req, out_valid, out_flit_id, out_length, out_data,
           preempt, err_seq
  );
endinterface

// File: rtl/flit_requester.sv
// Flit requester: buffers incoming flits in a small FIFO, requests the
// arbiter once a header sits at the head, streams the packet while granted,
// and recovers from a lost grant by re-requesting and resuming at the same
// flit. Stray non-header flits arriving between packets are discarded.
module flit_requester #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input logic              clk,
  input logic              rst,
  flit_requester_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 12 + DATA_W;
  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_TAIL = 3'b100;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] head;
  logic [2:0]    head_id;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          transfer;
  logic          discard;
  logic          pop;

  // The extra wrap bit tells a full FIFO apart from an empty one when the
  // index bits of both pointers coincide.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = bus.in_valid && !full;

  assign head    = mem[rd_ptr[AW-1:0]];
  assign head_id = head[EW-1 -: 3];

  // A flit leaves the FIFO either by going downstream or by being dropped
  // as a stray non-header while no packet is in progress.
  assign transfer = (state == SEND) && bus.grant && !empty;
  assign discard  = (state == IDLE) && !empty && (head_id != ID_HDR);
  assign pop      = transfer || discard;

  assign bus.in_ready    = !full;
  assign bus.out_valid   = transfer;
  assign bus.out_flit_id = head_id;
  assign bus.out_length  = head[DATA_W +: 12];
  assign bus.out_data    = head[DATA_W-1:0];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {bus.in_flit_id, bus.in_length, bus.in_data};
    end
  end

  // FIFO pointers; reset empties the FIFO and discards any partial packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Packet FSM with registered req and one-cycle preempt / err_seq pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bus.req     <= 1'b0;
      bus.preempt <= 1'b0;
      bus.err_seq <= 1'b0;
    end else begin
      bus.preempt <= 1'b0;
      bus.err_seq <= 1'b0;
      case (state)
        IDLE: begin
          bus.req <= 1'b0;
          if (!empty) begin
            if (head_id == ID_HDR) begin
              state   <= REQ;
              bus.req <= 1'b1;
            end else begin
              bus.err_seq <= 1'b1;
            end
          end
        end
        REQ: begin
          bus.req <= 1'b1;
          if (bus.grant) state <= SEND;
        end
        SEND: begin
          if (!bus.grant) begin
            state       <= REQ;
            bus.req     <= 1'b1;
            bus.preempt <= 1'b1;
          end else if (!empty && (head_id == ID_TAIL)) begin
            state   <= IDLE;
            bus.req <= 1'b0;
          end else begin
            bus.req <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bus.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flit_requester.sv
// Randomised bench for flit_requester: a packet-level reference model tracks
// the expected FIFO contents and packet phase and predicts every output.
module tb_flit_requester;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_SEND = 2;

  typedef struct {
    logic [2:0]        id;
    logic [11:0]       len;
    logic [DATA_W-1:0] data;
  } flit_t;

  logic clk = 1'b0;
  logic rst;

  flit_requester_if #(.DATA_W(DATA_W)) bus ();

  flit_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  flit_t q[$];
  int    phase;
  logic  exp_preempt;
  logic  exp_err;
  flit_t cur;
  logic  in_pkt;
  int    bodies_left;
  logic  drv_valid;
  logic  drv_grant;
  int    tests;
  int    fails;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Produces the next upstream flit: whole packets, sometimes a stray body.
  task automatic nextFlit();
    cur.data = $urandom;
    cur.len  = 12'($urandom);
    if (!in_pkt) begin
      if ($urandom_range(0, 9) == 0) begin
        cur.id = BODY;
      end else begin
        cur.id      = HDR;
        cur.len     = 12'($urandom_range(1, 4095));
        bodies_left = $urandom_range(0, 3);
        in_pkt      = 1'b1;
      end
    end else if (bodies_left > 0) begin
      cur.id = BODY;
      bodies_left--;
    end else begin
      cur.id = TAIL;
      in_pkt = 1'b0;
    end
  endtask

  task automatic resetModel();
    q.delete();
    phase       = PH_IDLE;
    exp_preempt = 1'b0;
    exp_err     = 1'b0;
  endtask

  task automatic compareCycle();
    checkOutput("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
    checkOutput("req", 64'(bus.req), 64'(phase != PH_IDLE));
    checkOutput("out_valid", 64'(bus.out_valid),
                64'(phase == PH_SEND && drv_grant && q.size() > 0));
    checkOutput("preempt", 64'(bus.preempt), 64'(exp_preempt));
    checkOutput("err_seq", 64'(bus.err_seq), 64'(exp_err));
    if (q.size() > 0) begin
      checkOutput("out_flit_id", 64'(bus.out_flit_id), 64'(q[0].id));
      checkOutput("out_length", 64'(bus.out_length), 64'(q[0].len));
      checkOutput("out_data", 64'(bus.out_data), 64'(q[0].data));
    end
  endtask

  // What one rising edge does to the packet phase and the stored flits.
  task automatic modelEdge();
    int   n;
    logic xfer;
    logic disc;
    logic acc;
    n    = q.size();
    xfer = (phase == PH_SEND) && drv_grant && (n > 0);
    disc = (phase == PH_IDLE) && (n > 0) && (q[0].id != HDR);
    acc  = drv_valid && (n < DEPTH);
    exp_preempt = (phase == PH_SEND) && !drv_grant;
    exp_err     = disc;
    case (phase)
      PH_IDLE: if (n > 0 && q[0].id == HDR) phase = PH_WAIT;
      PH_WAIT: if (drv_grant) phase = PH_SEND;
      default: begin
        if (!drv_grant) phase = PH_WAIT;
        else if (xfer && q[0].id == TAIL) phase = PH_IDLE;
      end
    endcase
    if (xfer || disc) void'(q.pop_front());
    if (acc) begin
      q.push_back(cur);
      nextFlit();
    end
  endtask

  task automatic driveInputs();
    bus.in_valid   = drv_valid;
    bus.grant      = drv_grant;
    bus.in_flit_id = cur.id;
    bus.in_length  = cur.len;
    bus.in_data    = cur.data;
  endtask

  // grant_mode: 0 grant low, 1 grant high, 2 grant toggles at random.
  task automatic applyStimulus(input int valid_pct, input int grant_mode, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drv_valid = ($urandom_range(0, 99) < valid_pct);
      case (grant_mode)
        0:       drv_grant = 1'b0;
        1:       drv_grant = 1'b1;
        default: if ($urandom_range(0, 4) == 0) drv_grant = ~drv_grant;
      endcase
      driveInputs();
      @(negedge clk);
      compareCycle();
      modelEdge();
      @(posedge clk);
      #1;
    end
  endtask

  // Pull reset asynchronously while a packet is being streamed.
  task automatic midReset();
    int guard;
    guard = 0;
    while (!(phase == PH_SEND && q.size() > 0) && guard < 200) begin
      applyStimulus(100, 1, 1);
      guard++;
    end
    checkOutput("reach_send", 64'(phase == PH_SEND && q.size() > 0), 64'd1);
    drv_grant = 1'b1;
    drv_valid = 1'b0;
    driveInputs();
    #1;
    checkOutput("pre_reset_out_valid", 64'(bus.out_valid), 64'(phase == PH_SEND && q.size() > 0));
    rst = 1'b0;
    #1;
    checkOutput("rst_req", 64'(bus.req), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    in_pkt      = 1'b0;
    bodies_left = 0;
    drv_valid   = 1'b0;
    drv_grant   = 1'b0;
    rst         = 1'b0;
    resetModel();
    nextFlit();
    driveInputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_req", 64'(bus.req), 64'd0);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_preempt", 64'(bus.preempt), 64'd0);
    checkOutput("reset_err_seq", 64'(bus.err_seq), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(60, 0, 24);
    applyStimulus(50, 1, 40);
    applyStimulus(70, 2, 400);
    applyStimulus(30, 1, 100);
    midReset();
    applyStimulus(60, 2, 400);
    applyStimulus(80, 0, 16);
    applyStimulus(0, 1, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
